// File: rtl/qspi_chan_arbiter.sv
// Round-robin arbiter between the AXI data channel and AHB control channel
// onto the single QSPI transfer request path, with completion watchdog.
module qspi_chan_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        dchan_req_valid,
  output logic        dchan_req_ready,
  input  logic [7:0]  dchan_req_data_size,
  input  logic [7:0]  dchan_req_data_burstlen,
  input  logic [7:0]  dchan_req_inst,
  input  logic [23:0] dchan_req_addr,
  input  logic        cchan_req_valid,
  output logic        cchan_req_ready,
  input  logic [7:0]  cchan_req_data_size,
  input  logic [7:0]  cchan_req_data_burstlen,
  input  logic [7:0]  cchan_req_inst,
  input  logic [23:0] cchan_req_addr,
  output logic        out_req_valid,
  input  logic        out_req_ready,
  output logic [7:0]  out_req_data_size,
  output logic [7:0]  out_req_data_burstlen,
  output logic [7:0]  out_req_inst,
  output logic [23:0] out_req_addr,
  input  logic        xfer_done,
  output logic        xfer_abort,
  output logic        owner_sel,
  output logic        tdata_lock,
  output logic        dchan_done,
  output logic        dchan_error,
  output logic        cchan_resp_valid,
  output logic        cchan_resp_error,
  output logic [1:0]  cchan_resp_cause
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_BUSY, S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] WD_LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  size_q, size_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  inst_q, inst_d;
  logic [23:0] addr_q, addr_d;
  logic        oval_q, oval_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic        lock_q, lock_d;
  logic        ddone_q, ddone_d;
  logic        derr_q, derr_d;
  logic        cval_q, cval_d;
  logic        cerr_q, cerr_d;
  logic [1:0]  ccause_q, ccause_d;

  logic        idle, gnt_c, gnt_d, wd_hit;
  logic        resp_en;
  logic [1:0]  resp_cause;

  // Grant decode: sole requester wins, a tie goes against last_grant.
  always_comb begin
    idle   = (state_q == S_IDLE);
    gnt_c  = cchan_req_valid & (~dchan_req_valid | ~last_q);
    gnt_d  = dchan_req_valid & (~cchan_req_valid | last_q);
    wd_hit = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LIM);
  end

  assign dchan_req_ready = idle & gnt_d & ~rst;
  assign cchan_req_ready = idle & gnt_c & ~rst;
  assign xfer_abort = (state_q == S_BUSY) & wd_hit & ~xfer_done;

  // Next-state, field latch, watchdog and response pulse computation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    size_d     = size_q;
    burst_d    = burst_q;
    inst_d     = inst_q;
    addr_d     = addr_q;
    oval_d     = oval_q;
    wd_d       = wd_q;
    resp_en    = 1'b0;
    resp_cause = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_c | gnt_d) begin
          owner_d = gnt_c;
          last_d  = gnt_c;
          size_d  = gnt_c ? cchan_req_data_size
                          : dchan_req_data_size;
          burst_d = gnt_c ? cchan_req_data_burstlen
                          : dchan_req_data_burstlen;
          inst_d  = gnt_c ? cchan_req_inst
                          : dchan_req_inst;
          addr_d  = gnt_c ? cchan_req_addr
                          : dchan_req_addr;
          if (size_d == 8'd0 || burst_d == 8'd0) begin
            state_d    = S_RESP;
            resp_en    = 1'b1;
            resp_cause = 2'b10;
          end else begin
            state_d = S_ISSUE;
            oval_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (out_req_ready) begin
          state_d = S_BUSY;
          oval_d  = 1'b0;
          wd_d    = '0;
        end
      end
      S_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (xfer_done) begin
          state_d = S_RESP;
          resp_en = 1'b1;
        end else if (wd_hit) begin
          state_d    = S_RESP;
          resp_en    = 1'b1;
          resp_cause = 2'b01;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ddone_d  = resp_en & ~owner_d;
    derr_d   = resp_en & ~owner_d & (resp_cause != 2'b00);
    cval_d   = resp_en & owner_d;
    cerr_d   = resp_en & owner_d & (resp_cause != 2'b00);
    ccause_d = (resp_en & owner_d) ? resp_cause : 2'b00;
    lock_d   = ~owner_d &
               (state_d == S_ISSUE || state_d == S_BUSY);
  end

  // State and registered outputs; reset abandons any transfer silently.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      size_q   <= '0;
      burst_q  <= '0;
      inst_q   <= '0;
      addr_q   <= '0;
      oval_q   <= 1'b0;
      wd_q     <= '0;
      lock_q   <= 1'b0;
      ddone_q  <= 1'b0;
      derr_q   <= 1'b0;
      cval_q   <= 1'b0;
      cerr_q   <= 1'b0;
      ccause_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      inst_q   <= inst_d;
      addr_q   <= addr_d;
      oval_q   <= oval_d;
      wd_q     <= wd_d;
      lock_q   <= lock_d;
      ddone_q  <= ddone_d;
      derr_q   <= derr_d;
      cval_q   <= cval_d;
      cerr_q   <= cerr_d;
      ccause_q <= ccause_d;
    end
  end

  assign out_req_valid         = oval_q;
  assign out_req_data_size     = size_q;
  assign out_req_data_burstlen = burst_q;
  assign out_req_inst          = inst_q;
  assign out_req_addr          = addr_q;
  assign owner_sel             = owner_q;
  assign tdata_lock            = lock_q;
  assign dchan_done            = ddone_q;
  assign dchan_error           = derr_q;
  assign cchan_resp_valid      = cval_q;
  assign cchan_resp_error      = cerr_q;
  assign cchan_resp_cause      = ccause_q;

endmodule
